// File: rtl/cnn_pixel_streamer.sv
// Frame buffer and row-major pixel streamer feeding the CNN input port.
// The image is loaded through a write port, then streamed on a start pulse, with optional idle gaps between rows.
module cnn_pixel_streamer #(
  parameter int unsigned IX       = 28,
  parameter int unsigned IY       = 28,
  parameter int unsigned I_F_BW   = 8,
  parameter int unsigned LINE_GAP = 0,
  parameter int unsigned ADDR_W   = $clog2(IX * IY)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [I_F_BW-1:0] i_wr_data,
  input  logic              i_start,
  output logic              o_valid,
  output logic [I_F_BW-1:0] o_pixel,
  output logic              o_last,
  output logic              o_done,
  output logic              o_busy,
  output logic              o_wr_err
);

  localparam int unsigned NPIX = IX * IY;
  localparam int unsigned XW   = (IX > 1) ? $clog2(IX) : 1;
  localparam int unsigned YW   = (IY > 1) ? $clog2(IY) : 1;
  localparam int unsigned GW   = (LINE_GAP > 1) ? $clog2(LINE_GAP) : 1;

  localparam logic [XW-1:0] X_LAST   = XW'(IX - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(IY - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(LINE_GAP - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_GAP    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              wr_err_q, wr_err_d;
  logic [I_F_BW-1:0] pix_q;

  logic              idle_c;
  logic              wr_ok_c;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;

  logic [I_F_BW-1:0] mem [NPIX];

  // Next-state, counters and output pipeline inputs.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    gap_d     = gap_q;
    rd_en_c   = 1'b0;
    last_d    = 1'b0;
    done_d    = 1'b0;
    // busy_q still high during the o_done cycle keeps writes and starts out until it falls
    idle_c    = (state_q == S_IDLE) && !busy_q;
    wr_ok_c   = i_wr_en && idle_c && (32'(i_wr_addr) < NPIX);
    wr_err_d  = i_wr_en && !wr_ok_c;
    rd_addr_c = ADDR_W'(32'(y_q) * IX + 32'(x_q));

    case (state_q)
      S_IDLE: begin
        if (i_start && idle_c) begin
          state_d = S_STREAM;
          x_d     = '0;
          y_d     = '0;
          gap_d   = '0;
        end
      end
      S_STREAM: begin
        rd_en_c = 1'b1;
        last_d  = (x_q == X_LAST) && (y_q == Y_LAST);
        if (x_q == X_LAST) begin
          x_d = '0;
          if (y_q == Y_LAST) begin
            y_d     = '0;
            state_d = S_DONE;
          end else begin
            y_d = y_q + YW'(1);
            if (LINE_GAP > 0) begin
              state_d = S_GAP;
              gap_d   = '0;
            end
          end
        end else begin
          x_d = x_q + XW'(1);
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_STREAM;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = rd_en_c;
    busy_d  = (state_d != S_IDLE) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Registered read port doubles as the o_pixel pipeline stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      pix_q <= '0;
    end else if (rd_en_c) begin
      pix_q <= mem[rd_addr_c];
    end
  end

  assign o_valid  = valid_q;
  assign o_pixel  = pix_q;
  assign o_last   = last_q;
  assign o_done   = done_q;
  assign o_busy   = busy_q;
  assign o_wr_err = wr_err_q;

endmodule

// File: tb/tb_cnn_pixel_streamer.sv
// Bench for cnn_pixel_streamer: two instances (LINE_GAP 0 and 3) share stimulus and are checked against an image model.
module tb_cnn_pixel_streamer;

  localparam int unsigned IX   = 28;
  localparam int unsigned IY   = 28;
  localparam int unsigned NPIX = IX * IY;
  localparam int unsigned AW   = 10;
  localparam int          CAP  = 8192;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_wr_en;
  logic [AW-1:0] i_wr_addr;
  logic [7:0]    i_wr_data;
  logic          i_start;

  logic [1:0]      vld, lst, dn, bsy, werr;
  logic [1:0][7:0] pix;

  always #5 clk = ~clk;

  cnn_pixel_streamer #(.IX(IX), .IY(IY), .I_F_BW(8), .LINE_GAP(0)) dut0 (
    .clk(clk), .reset(reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .o_valid(vld[0]), .o_pixel(pix[0]),
    .o_last(lst[0]), .o_done(dn[0]), .o_busy(bsy[0]), .o_wr_err(werr[0])
  );

  cnn_pixel_streamer #(.IX(IX), .IY(IY), .I_F_BW(8), .LINE_GAP(3)) dut1 (
    .clk(clk), .reset(reset), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .o_valid(vld[1]), .o_pixel(pix[1]),
    .o_last(lst[1]), .o_done(dn[1]), .o_busy(bsy[1]), .o_wr_err(werr[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  logic [7:0] img_m [NPIX];

  int         cap_n    [2] = '{0, 0};
  int         cap_cyc  [2][CAP];
  logic [7:0] cap_pix  [2][CAP];
  logic       cap_last [2][CAP];
  int         done_n   [2] = '{0, 0};
  int         done_cyc [2][64];
  int         busy_n   [2] = '{0, 0};
  int         err_n    [2] = '{0, 0};

  always @(posedge clk) cyc <= cyc + 1;

  // Output log sampled mid-cycle.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (vld[d] === 1'b1) begin
        if (cap_n[d] < CAP) begin
          cap_cyc[d][cap_n[d]]  = cyc;
          cap_pix[d][cap_n[d]]  = pix[d];
          cap_last[d][cap_n[d]] = lst[d];
        end
        cap_n[d]++;
      end
      if (dn[d] === 1'b1) begin
        if (done_n[d] < 64) done_cyc[d][done_n[d]] = cyc;
        done_n[d]++;
      end
      if (bsy[d] === 1'b1) busy_n[d]++;
      if (werr[d] === 1'b1) err_n[d]++;
    end
  end

  function automatic int gap_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_image(input bit random_fill);
    for (int i = 0; i < int'(NPIX); i++) begin
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(i);
      i_wr_data = random_fill ? 8'($urandom) : 8'(i);
      img_m[i]  = i_wr_data;
      tick();
    end
    i_wr_en = 1'b0;
    tick();
  endtask

  // Starts a frame (optionally with a same-cycle write), optionally pokes a write+start mid-frame, then checks both streams.
  task automatic run_frame(input string tag, input bit with_wr, input int wa, input logic [7:0] wd,
                           input int act_at, input int tail);
    int c_base [2];
    int d_base [2];
    int b_base [2];
    int t0, budget, gap, n, errs, bad_i, exp_c, last_c;
    logic [7:0] poke;
    for (int d = 0; d < 2; d++) begin
      c_base[d] = cap_n[d];
      d_base[d] = done_n[d];
      b_base[d] = busy_n[d];
    end
    poke    = ~img_m[100];
    i_start = 1'b1;
    if (with_wr) begin
      i_wr_en   = 1'b1;
      i_wr_addr = AW'(wa);
      i_wr_data = wd;
      img_m[wa] = wd;
    end
    tick();
    t0      = cyc;
    i_start = 1'b0;
    i_wr_en = 1'b0;
    budget  = 0;
    while ((done_n[0] == d_base[0] || done_n[1] == d_base[1]) && budget < 3000) begin
      if (budget == act_at) begin
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(100);
        i_wr_data = poke;
        i_start   = 1'b1;
      end else begin
        i_wr_en = 1'b0;
        i_start = 1'b0;
      end
      tick();
      budget++;
    end
    i_wr_en = 1'b0;
    i_start = 1'b0;
    n_chk++;
    if (budget >= 3000) $display("FAIL %s timeout: no o_done within %0d cycles", tag, budget);
    else n_pass++;
    for (int k = 0; k < tail; k++) tick();

    for (int d = 0; d < 2; d++) begin
      gap = gap_of(d);
      n   = cap_n[d] - c_base[d];
      n_chk++;
      if (n !== int'(NPIX)) $display("FAIL %s dut%0d valid count: got %0d want %0d", tag, d, n, NPIX);
      else n_pass++;

      errs  = 0;
      bad_i = -1;
      for (int i = 0; i < int'(NPIX) && i < n && (c_base[d] + i) < CAP; i++) begin
        exp_c = t0 + 1 + i + (i / int'(IX)) * gap;
        if (cap_pix[d][c_base[d]+i] !== img_m[i] || cap_cyc[d][c_base[d]+i] !== exp_c ||
            cap_last[d][c_base[d]+i] !== (i == int'(NPIX) - 1)) begin
          if (bad_i < 0) bad_i = i;
          errs++;
        end
      end
      n_chk++;
      if (errs != 0)
        $display("FAIL %s dut%0d stream: %0d bad pixels, first idx %0d got pix %0h cyc %0d last %b want pix %0h cyc %0d",
                 tag, d, errs, bad_i, cap_pix[d][c_base[d]+bad_i], cap_cyc[d][c_base[d]+bad_i] - t0,
                 cap_last[d][c_base[d]+bad_i], img_m[bad_i], 1 + bad_i + (bad_i / int'(IX)) * gap);
      else n_pass++;

      last_c = t0 + int'(NPIX) + (int'(IY) - 1) * gap;
      n_chk++;
      if (done_n[d] - d_base[d] !== 1) $display("FAIL %s dut%0d done count: got %0d want 1", tag, d, done_n[d] - d_base[d]);
      else n_pass++;
      n_chk++;
      if (d_base[d] >= 64 || done_cyc[d][d_base[d]] !== last_c + 1)
        $display("FAIL %s dut%0d done timing: got %0d want %0d", tag, d, done_cyc[d][d_base[d] % 64] - t0, last_c + 1 - t0);
      else n_pass++;
      n_chk++;
      if (busy_n[d] - b_base[d] !== last_c + 2 - t0)
        $display("FAIL %s dut%0d busy cycles: got %0d want %0d", tag, d, busy_n[d] - b_base[d], last_c + 2 - t0);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    i_wr_en   = 1'b0;
    i_wr_addr = '0;
    i_wr_data = '0;
    i_start   = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({vld[d], lst[d], dn[d], bsy[d], werr[d]} !== 5'b0 || pix[d] !== 8'h00)
        $display("FAIL reset dut%0d outputs: got v%b l%b d%b b%b e%b p%0h want all 0",
                 d, vld[d], lst[d], dn[d], bsy[d], werr[d], pix[d]);
      else n_pass++;
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ramp_frame();
    load_image(1'b0);
    run_frame("ramp", 1'b0, 0, 8'h00, -1, 3);
  endtask

  task automatic test_random_frame();
    load_image(1'b1);
    run_frame("random", 1'b0, 0, 8'h00, -1, 3);
  endtask

  task automatic test_busy_write();
    int e_base [2];
    for (int d = 0; d < 2; d++) e_base[d] = err_n[d];
    run_frame("busy_write", 1'b0, 0, 8'h00, 40 + int'($urandom_range(0, 200)), 3);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (err_n[d] - e_base[d] !== 1) $display("FAIL busy_write dut%0d wr_err pulses: got %0d want 1", d, err_n[d] - e_base[d]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_addr();
    int e_base [2];
    for (int d = 0; d < 2; d++) e_base[d] = err_n[d];
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(NPIX);
    i_wr_data = 8'($urandom);
    tick();
    i_wr_addr = AW'($urandom_range(NPIX + 1, 1023));
    i_wr_data = 8'($urandom);
    tick();
    i_wr_en = 1'b0;
    repeat (2) tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (err_n[d] - e_base[d] !== 2) $display("FAIL bad_addr dut%0d wr_err pulses: got %0d want 2", d, err_n[d] - e_base[d]);
      else n_pass++;
    end
    run_frame("wr_with_start", 1'b1, 5, ~img_m[5], -1, 3);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (err_n[d] - e_base[d] !== 2) $display("FAIL wr_with_start dut%0d wr_err pulses: got %0d want 2", d, err_n[d] - e_base[d]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    int c_base, budget;
    int d_base [2];
    c_base = cap_n[0];
    for (int d = 0; d < 2; d++) d_base[d] = done_n[d];
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    budget  = 0;
    while (cap_n[0] - c_base < 300 && budget < 2000) begin
      tick();
      budget++;
    end
    reset = 1'b1;
    tick();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if ({vld[d], bsy[d], lst[d], dn[d]} !== 4'b0)
        $display("FAIL reset_mid dut%0d outputs: got v%b b%b l%b d%b want 0", d, vld[d], bsy[d], lst[d], dn[d]);
      else n_pass++;
    end
    #1;
    reset = 1'b0;
    repeat (6) tick();
    for (int d = 0; d < 2; d++) begin
      n_chk++;
      if (done_n[d] !== d_base[d] || bsy[d] !== 1'b0)
        $display("FAIL reset_mid dut%0d aborted frame: dones %0d busy %b want 0 and 0", d, done_n[d] - d_base[d], bsy[d]);
      else n_pass++;
    end
    run_frame("after_reset", 1'b0, 0, 8'h00, -1, 3);
  endtask

  task automatic test_back_to_back();
    load_image(1'b1);
    run_frame("b2b_first", 1'b0, 0, 8'h00, -1, 0);
    run_frame("b2b_second", 1'b0, 0, 8'h00, -1, 3);
  endtask

  initial begin
    test_reset();
    test_ramp_frame();
    test_random_frame();
    test_busy_write();
    test_bad_addr();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
